// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples SCLK/CS/MOSI on clk, exchanges LSB-first frames
// with local logic through a TX holding register and an RX word with valid pulse.
module spi_slave #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  frameError,
  output logic                  busy
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                    sclk_dly_q, cs_dly_q;
  logic [DATA_WIDTH-1:0]   hold_q, shift_tx_q, shift_rx_q;
  logic [CntW-1:0]         bitcnt_q;

  logic                    sclk_s, cs_s, mosi_s;
  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall, last_fall;
  logic [DATA_WIDTH-1:0]   rx_next;

  // Synchronizers reset to the bus idle levels so reset never creates a spurious edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;
  assign rx_next   = {mosi_s, shift_rx_q[DATA_WIDTH-1:1]};
  assign last_fall = sclk_fall && (bitcnt_q == LastBit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      MISO              <= 1'b0;
      txReady           <= 1'b1;
      slaveDataReceived <= '0;
      rxValid           <= 1'b0;
      frameError        <= 1'b0;
      busy              <= 1'b0;
      hold_q            <= '0;
      shift_tx_q        <= '0;
      shift_rx_q        <= '0;
      bitcnt_q          <= '0;
    end else begin
      rxValid    <= 1'b0;
      frameError <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (txLoad) hold_q <= slaveDataToSend;
          if (cs_fall) begin
            state_q    <= StShift;
            shift_tx_q <= hold_q;
            bitcnt_q   <= '0;
            busy       <= 1'b1;
            txReady    <= 1'b0;
          end
        end
        StShift: begin
          if (sclk_rise) begin
            MISO       <= shift_tx_q[0];
            shift_tx_q <= shift_tx_q >> 1;
          end
          if (sclk_fall) begin
            shift_rx_q <= rx_next;
            bitcnt_q   <= bitcnt_q + 1'b1;
          end
          if (last_fall) begin
            slaveDataReceived <= rx_next;
            rxValid           <= 1'b1;
            state_q           <= StHold;
            txReady           <= 1'b1;
          end
          // A CS release coinciding with the last fall still completes the word.
          if (cs_rise) begin
            if (!last_fall) frameError <= 1'b1;
            state_q <= StIdle;
            busy    <= 1'b0;
            txReady <= 1'b1;
            MISO    <= 1'b0;
          end
        end
        StHold: begin
          if (txLoad) hold_q <= slaveDataToSend;
          if (cs_rise) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            MISO    <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: an SPI master model drives frames, expected MISO bits
// and RX words are queued at stimulus time and compared when the DUT produces them.
module tb_spi_slave;
  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset, SCLK, CS, MOSI, MISO;
  logic [W-1:0] slaveDataToSend, slaveDataReceived;
  logic         txLoad, txReady, rxValid, frameError, busy;

  int n_checks = 0;
  int n_errors = 0;
  int rx_pulses = 0;
  int fe_pulses = 0;
  int half = 6;
  int rx0, fe0;

  logic [W-1:0] exp_rx_q[$];
  logic         exp_miso_q[$];

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk               (clk),
    .reset             (reset),
    .SCLK              (SCLK),
    .CS                (CS),
    .MOSI              (MOSI),
    .MISO              (MISO),
    .slaveDataToSend   (slaveDataToSend),
    .txLoad            (txLoad),
    .txReady           (txReady),
    .slaveDataReceived (slaveDataReceived),
    .rxValid           (rxValid),
    .frameError        (frameError),
    .busy              (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rxValid) begin
      rx_pulses++;
      if (exp_rx_q.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
      else check("rx_data", slaveDataReceived, exp_rx_q.pop_front());
    end
    if (frameError) fe_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [W-1:0] d);
    slaveDataToSend = d;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
  endtask

  task automatic push_tx(input logic [W-1:0] d, input int n);
    for (int i = 0; i < n; i++) exp_miso_q.push_back(d[i]);
  endtask

  task automatic begin_frame();
    CS = 1'b0;
    idle(half);
    check("busy_in_frame", busy, 1);
    check("txready_in_frame", txReady, 0);
  endtask

  // SCLK periods lo..hi-1; MOSI changes with the rise, MISO is sampled just before the fall.
  task automatic bits(input logic [W-1:0] word, input int lo, input int hi);
    logic [W-1:0] sh;
    for (int i = lo; i < hi; i++) begin
      sh   = word >> i;
      SCLK = 1'b1;
      MOSI = (i < W) ? sh[0] : 1'b0;
      idle(half);
      if (exp_miso_q.size() > 0) check("miso_bit", MISO, exp_miso_q.pop_front());
      SCLK = 1'b0;
      idle(half);
    end
  endtask

  task automatic end_frame();
    CS = 1'b1;
    idle(half + 2);
    check("miso_after_cs", MISO, 0);
    check("busy_after_cs", busy, 0);
  endtask

  initial begin
    reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    txLoad = 1'b0; slaveDataToSend = '0;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("rst_miso", MISO, 0);
    check("rst_txready", txReady, 1);
    check("rst_rxdata", slaveDataReceived, 0);
    check("rst_rxvalid", rxValid, 0);
    check("rst_frameerror", frameError, 0);
    check("rst_busy", busy, 0);

    // 1: full frame, A5 out, 3C in
    rx0 = rx_pulses; fe0 = fe_pulses;
    load(8'hA5);
    push_tx(8'hA5, W);
    exp_rx_q.push_back(8'h3C);
    begin_frame();
    bits(8'h3C, 0, W);
    check("hold_busy", busy, 1);
    check("hold_txready", txReady, 1);
    end_frame();
    check("t1_rx_pulses", rx_pulses - rx0, 1);
    check("t1_fe_pulses", fe_pulses - fe0, 0);
    check("t1_rxdata", slaveDataReceived, 8'h3C);

    // 2: abort after 5 periods
    rx0 = rx_pulses; fe0 = fe_pulses;
    push_tx(8'hA5, 5);
    begin_frame();
    bits(8'hC7, 0, 5);
    end_frame();
    check("t2_fe_pulses", fe_pulses - fe0, 1);
    check("t2_rx_pulses", rx_pulses - rx0, 0);
    check("t2_rxdata_kept", slaveDataReceived, 8'h3C);

    // 3: txLoad ignored mid-frame, holding retransmitted
    load(8'h11);
    push_tx(8'h11, W);
    exp_rx_q.push_back(8'h5A);
    begin_frame();
    bits(8'h5A, 0, 2);
    slaveDataToSend = 8'hFF;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
    check("t3_txready_shift", txReady, 0);
    bits(8'h5A, 2, W);
    end_frame();
    push_tx(8'h11, W);
    exp_rx_q.push_back(8'hC3);
    begin_frame();
    bits(8'hC3, 0, W);
    end_frame();

    // 4: extra SCLK periods in HOLD; MISO holds bit 7
    rx0 = rx_pulses;
    load(8'hE1);
    push_tx(8'hE1, W);
    for (int i = 0; i < 3; i++) exp_miso_q.push_back(1'b1);
    exp_rx_q.push_back(8'h77);
    begin_frame();
    bits(8'h77, 0, W + 3);
    check("t4_miso_hold", MISO, 1);
    end_frame();
    check("t4_rx_pulses", rx_pulses - rx0, 1);

    // 5: reset mid-frame, holding cleared, then a clean frame
    fe0 = fe_pulses;
    load(8'hFF);
    push_tx(8'hFF, 4);
    begin_frame();
    bits(8'h96, 0, 4);
    SCLK = 1'b1;
    idle(half);
    check("t5_miso_pre_reset", MISO, 1);
    reset = 1'b1; CS = 1'b1; SCLK = 1'b0;
    idle(1);
    check("t5_miso", MISO, 0);
    check("t5_txready", txReady, 1);
    check("t5_rxdata", slaveDataReceived, 0);
    check("t5_busy", busy, 0);
    check("t5_rxvalid", rxValid, 0);
    reset = 1'b0;
    idle(6);
    check("t5_no_fe", fe_pulses - fe0, 0);
    push_tx(8'h00, W);
    exp_rx_q.push_back(8'h96);
    begin_frame();
    bits(8'h96, 0, W);
    end_frame();
    check("t5_rxdata_after", slaveDataReceived, 8'h96);

    // 6: minimum SCLK phase, back-to-back frames
    half = SS + 2;
    rx0 = rx_pulses;
    load(8'h3C);
    push_tx(8'h3C, W);
    exp_rx_q.push_back(8'h01);
    begin_frame();
    bits(8'h01, 0, W);
    end_frame();
    push_tx(8'h3C, W);
    exp_rx_q.push_back(8'h80);
    begin_frame();
    bits(8'h80, 0, W);
    end_frame();
    check("t6_rx_pulses", rx_pulses - rx0, 2);

    check("rx_queue_empty", exp_rx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
